// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution unit and its predictor table.
package branch_pkg;

  typedef enum logic [2:0] {
    BC_BEQ  = 3'b000,
    BC_BNE  = 3'b001,
    BC_BLT  = 3'b100,
    BC_BGE  = 3'b101,
    BC_BLTU = 3'b110,
    BC_BGEU = 3'b111
  } b_control_e;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_INIT_DEFAULT = 2'b01;
  localparam int       PC_ALIGN_BITS    = 2;

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Fetch lookup, execute-stage branch inputs and registered resolution results.
interface branch_predict_resolve_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            stall;
  logic            res_valid;
  logic [2:0]      b_control;
  logic [XLEN-1:0] r1;
  logic [XLEN-1:0] r2;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] res_imm;
  logic            res_pred_taken;
  logic            br_valid;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            br_illegal;
  logic [31:0]     mispredict_count;

  modport master (
    output pred_pc, stall, res_valid, b_control, r1, r2, res_pc, res_imm, res_pred_taken,
    input  pred_taken, br_valid, br_taken, br_target, mispredict, redirect_pc, br_illegal,
           mispredict_count
  );

  modport slave (
    input  pred_pc, stall, res_valid, b_control, r1, r2, res_pc, res_imm, res_pred_taken,
    output pred_taken, br_valid, br_taken, br_target, mispredict, redirect_pc, br_illegal,
           mispredict_count
  );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation; codes 010/011 are flagged illegal and never taken.
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      b_control,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  output logic            taken,
  output logic            illegal
);

  logic signed [XLEN-1:0] r1_s;
  logic signed [XLEN-1:0] r2_s;

  assign r1_s = r1;
  assign r2_s = r2;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (b_control)
      BC_BEQ:  taken = (r1 == r2);
      BC_BNE:  taken = (r1 != r2);
      BC_BLT:  taken = (r1_s <  r2_s);
      BC_BGE:  taken = (r1_s >= r2_s);
      BC_BLTU: taken = (r1 <  r2);
      BC_BGEU: taken = (r1 >= r2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch resolution with a bimodal 2-bit predictor: one-cycle registered results,
// table training on legal resolved branches and a saturating mispredict counter.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int       XLEN        = 32,
  parameter int       BHT_ENTRIES = 64,
  parameter bht_cnt_t CNT_INIT    = CNT_INIT_DEFAULT
) (
  input logic                     clk,
  input logic                     rst,
  branch_predict_resolve_if.slave bus
);

  localparam int IDX_W   = $clog2(BHT_ENTRIES);
  localparam int IDX_LSB = PC_ALIGN_BITS;
  localparam int IDX_MSB = IDX_W + PC_ALIGN_BITS - 1;

  function automatic logic [IDX_W-1:0] bht_idx(input logic [XLEN-1:0] pc);
    return pc[IDX_MSB:IDX_LSB];
  endfunction

  function automatic bht_cnt_t sat_step(input bht_cnt_t cnt, input logic up);
    bht_cnt_t nxt;
    nxt = cnt;
    if (up && cnt != 2'b11) begin
      nxt = cnt + 2'b01;
    end else if (!up && cnt != 2'b00) begin
      nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  bht_cnt_t bht [BHT_ENTRIES];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_pred_pc;

  logic            taken_c;
  logic            illegal_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] fallthrough_c;
  logic [XLEN-1:0] redirect_c;
  logic            mispredict_c;
  logic            accept;
  logic            train;

  logic            vld_p1;
  logic            taken_p1;
  logic [XLEN-1:0] target_p1;
  logic            mispredict_p1;
  logic [XLEN-1:0] redirect_p1;
  logic            illegal_p1;
  logic [31:0]     count_p1;

  assign pred_idx       = bht_idx(bus.pred_pc);
  assign upd_idx        = bht_idx(bus.res_pc);
  assign unused_pred_pc = ^{bus.pred_pc[XLEN-1:IDX_MSB+1], bus.pred_pc[IDX_LSB-1:0]};

  // Lookup reads the table as it stands; an update this cycle becomes visible after the edge.
  assign bus.pred_taken = bht[pred_idx][1];

  // Stage 0: condition, target and redirect from execute-stage operands
  branch_cond #(
    .XLEN (XLEN)
  ) u_cond (
    .b_control (bus.b_control),
    .r1        (bus.r1),
    .r2        (bus.r2),
    .taken     (taken_c),
    .illegal   (illegal_c)
  );

  assign target_c      = bus.res_pc + bus.res_imm;
  assign fallthrough_c = bus.res_pc + XLEN'(4);
  assign redirect_c    = taken_c ? target_c : fallthrough_c;
  assign mispredict_c  = (taken_c != bus.res_pred_taken);
  assign accept        = bus.res_valid && !bus.stall;
  assign train         = accept && !illegal_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CNT_INIT;
      end
    end else if (train) begin
      bht[upd_idx] <= sat_step(bht[upd_idx], taken_c);
    end
  end

  // Stage 1: registered resolution; data fields hold across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      taken_p1      <= 1'b0;
      target_p1     <= '0;
      mispredict_p1 <= 1'b0;
      redirect_p1   <= '0;
      illegal_p1    <= 1'b0;
      count_p1      <= '0;
    end else if (!bus.stall) begin
      vld_p1 <= bus.res_valid;
      if (bus.res_valid) begin
        taken_p1      <= taken_c;
        target_p1     <= target_c;
        mispredict_p1 <= mispredict_c;
        redirect_p1   <= redirect_c;
        illegal_p1    <= illegal_c;
        if (mispredict_c) begin
          count_p1 <= sat_inc32(count_p1);
        end
      end else begin
        mispredict_p1 <= 1'b0;
        illegal_p1    <= 1'b0;
      end
    end
  end

  assign bus.br_valid         = vld_p1;
  assign bus.br_taken         = taken_p1;
  assign bus.br_target        = target_p1;
  assign bus.mispredict       = mispredict_p1;
  assign bus.redirect_pc      = redirect_p1;
  assign bus.br_illegal       = illegal_p1;
  assign bus.mispredict_count = count_p1;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed and randomized checks of branch_predict_resolve against a behavioural model.
module tb_branch_predict_resolve;

  localparam int ENTRIES = 64;

  logic clk;
  logic rst;

  branch_predict_resolve_if #(.XLEN(32)) bus ();

  branch_predict_resolve #(
    .XLEN        (32),
    .BHT_ENTRIES (ENTRIES),
    .CNT_INIT    (2'b01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  int          bht_m [ENTRIES];
  logic        m_valid;
  logic        m_taken;
  logic [31:0] m_target;
  logic        m_misp;
  logic [31:0] m_redir;
  logic        m_ill;
  logic [31:0] m_count;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_cond(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic t, output logic ill);
    t   = 1'b0;
    ill = 1'b0;
    case (c)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = (int'(a) <  int'(b));
      3'd5: t = (int'(a) >= int'(b));
      3'd6: t = (longint'(a) <  longint'(b));
      3'd7: t = (longint'(a) >= longint'(b));
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                       input logic pred, input logic [31:0] ppc);
    bus.res_valid      = v;
    bus.b_control      = code;
    bus.r1             = a;
    bus.r2             = b;
    bus.res_pc         = pc;
    bus.res_imm        = imm;
    bus.res_pred_taken = pred;
    bus.pred_pc        = ppc;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input logic rst_i, input logic stall_i);
    int          pi;
    int          ui;
    logic        t;
    logic        ill;
    logic [31:0] tgt;
    rst       = rst_i;
    bus.stall = stall_i;
    #1;
    pi = int'((bus.pred_pc >> 2) % ENTRIES);
    chk("pred_taken", bus.pred_taken, (bht_m[pi] >= 2));
    if (rst_i) begin
      m_valid = 0; m_taken = 0; m_target = 0; m_misp = 0; m_redir = 0; m_ill = 0; m_count = 0;
      foreach (bht_m[i]) bht_m[i] = 1;
    end else if (!stall_i) begin
      if (bus.res_valid) begin
        ref_cond(bus.b_control, bus.r1, bus.r2, t, ill);
        tgt      = bus.res_pc + bus.res_imm;
        m_valid  = 1;
        m_taken  = t;
        m_target = tgt;
        m_redir  = t ? tgt : bus.res_pc + 32'd4;
        m_ill    = ill;
        m_misp   = (t != bus.res_pred_taken);
        if (m_misp && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        if (!ill) begin
          ui = int'((bus.res_pc >> 2) % ENTRIES);
          if (t) bht_m[ui] = (bht_m[ui] == 3) ? 3 : bht_m[ui] + 1;
          else   bht_m[ui] = (bht_m[ui] == 0) ? 0 : bht_m[ui] - 1;
        end
      end else begin
        m_valid = 0;
        m_misp  = 0;
        m_ill   = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("br_valid",    bus.br_valid,         m_valid);
    chk("br_taken",    bus.br_taken,         m_taken);
    chk("br_target",   bus.br_target,        m_target);
    chk("mispredict",  bus.mispredict,       m_misp);
    chk("redirect_pc", bus.redirect_pc,      m_redir);
    chk("br_illegal",  bus.br_illegal,       m_ill);
    chk("misp_count",  bus.mispredict_count, m_count);
    @(negedge clk);
  endtask

  task automatic sweep_table();
    for (int i = 0; i < ENTRIES; i++) begin
      drive(1'b1, 3'd0, 32'd1, 32'd1, 32'h40, 32'h8, 1'b0, 32'(i) << 2);
      cycle(1'b0, 1'b1);
    end
  endtask

  logic [31:0] a, b, pc, ppc;
  logic [31:0] cnt_before;

  initial begin
    checks   = 0;
    failures = 0;
    foreach (bht_m[i]) bht_m[i] = 1;
    m_valid = 0; m_taken = 0; m_target = 0; m_misp = 0; m_redir = 0; m_ill = 0; m_count = 0;
    rst       = 1'b1;
    bus.stall = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h100);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset with a branch presented: outputs zero, table at CNT_INIT
    drive(1'b1, 3'd1, 32'd1, 32'd2, 32'h80, 32'h10, 1'b0, 32'h100);
    cycle(1'b1, 1'b0);
    chk("rst_count", bus.mispredict_count, 32'd0);

    // BEQ 5==5 from 0x100, predicted not taken
    drive(1'b1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h100);
    cycle(1'b0, 1'b0);
    chk("tp_beq_taken",  bus.br_taken,         1'b1);
    chk("tp_beq_target", bus.br_target,        32'h120);
    chk("tp_beq_misp",   bus.mispredict,       1'b1);
    chk("tp_beq_redir",  bus.redirect_pc,      32'h120);
    chk("tp_beq_count",  bus.mispredict_count, 32'd1);
    chk("tp_beq_pred",   bus.pred_taken,       1'b1);

    // Signed vs unsigned less-than on the same operands
    drive(1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 32'h300);
    cycle(1'b0, 1'b0);
    chk("tp_blt_taken", bus.br_taken, 1'b1);
    drive(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 32'h300);
    cycle(1'b0, 1'b0);
    chk("tp_bltu_taken", bus.br_taken,    1'b0);
    chk("tp_bltu_redir", bus.redirect_pc, 32'h304);

    // Saturation on one index: 3 taken, then 4 not taken
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd1, 32'd1, 32'd2, 32'h200, 32'h8, 1'b1, 32'h200);
      cycle(1'b0, 1'b0);
    end
    chk("tp_sat_hi_pred", bus.pred_taken, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd1, 32'd3, 32'd3, 32'h200, 32'h8, 1'b0, 32'h200);
      cycle(1'b0, 1'b0);
    end
    chk("tp_sat_lo_pred", bus.pred_taken, 1'b0);
    drive(1'b1, 3'd0, 32'd3, 32'd3, 32'h200, 32'h8, 1'b0, 32'h200);
    cycle(1'b0, 1'b0);
    chk("tp_from_zero_pred", bus.pred_taken, 1'b0);

    // Illegal code with predicted taken: mispredict, no training
    drive(1'b1, 3'd3, 32'd7, 32'd7, 32'h200, 32'h8, 1'b1, 32'h200);
    cycle(1'b0, 1'b0);
    chk("tp_ill_flag",  bus.br_illegal, 1'b1);
    chk("tp_ill_taken", bus.br_taken,   1'b0);
    chk("tp_ill_misp",  bus.mispredict, 1'b1);

    // Stall with a valid branch, then release
    cnt_before = bus.mispredict_count;
    drive(1'b1, 3'd0, 32'd9, 32'd9, 32'h500, 32'h100, 1'b0, 32'h500);
    cycle(1'b0, 1'b1);
    chk("tp_stall_count", bus.mispredict_count, cnt_before);
    chk("tp_stall_pred",  bus.pred_taken,       1'b0);
    cycle(1'b0, 1'b0);
    chk("tp_unstall_target", bus.br_target, 32'h600);

    // Address wrap for target and fall-through
    drive(1'b1, 3'd0, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'h0);
    cycle(1'b0, 1'b0);
    chk("tp_wrap_target", bus.br_target, 32'h4);
    drive(1'b1, 3'd1, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'd8, 1'b0, 32'h0);
    cycle(1'b0, 1'b0);
    chk("tp_wrap_fall", bus.redirect_pc, 32'h0);

    // Mid-stream reset with a branch presented
    drive(1'b1, 3'd1, 32'd1, 32'd2, 32'h100, 32'h20, 1'b0, 32'h100);
    cycle(1'b1, 1'b0);
    chk("tp_rst_valid", bus.br_valid,  1'b0);
    chk("tp_rst_redir", bus.redirect_pc, 32'h0);
    sweep_table();

    // Randomized traffic concentrated on a few table entries
    for (int n = 0; n < 1500; n++) begin
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      ppc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, pc, $urandom,
            1'($urandom_range(0, 1)), ppc);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0);
    end
    sweep_table();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
